// File: rtl/sio_host_arbiter_pkg.sv
// Shared widths, the in-flight tag record and a saturating counter helper
// for the SIO host-side command arbiter.
package sio_host_arbiter_pkg;

    localparam int SIO_CMD_W = 80;   // one command word per link frame
    localparam int SIO_RD_W  = 32;   // one read word returned per link frame
    localparam int ID_W      = 3;    // enough to name up to 8 requesters
    localparam int CNT_W     = 16;   // status counters

    // One frame's worth of bookkeeping: did a command go out, whose was it,
    // and was the link already unhealthy when it went.
    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
        logic            e;
    } tag_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/sio_host_arbiter_rr.sv
// Combinational round-robin pick: the first requester after ptr, searching
// cyclically, wins. Gives both a one-hot grant and its encoded index.
module sio_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      idx,
    output logic            any
);

    logic [7:0] req_ext;
    logic [3:0] cand;

    assign req_ext = 8'(req);

    // Walk ptr+1, ptr+2, ... wrapping at NREQ; keep the first active request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 4'(ptr) + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (!any && req_ext[cand[2:0]]) begin
                any = 1'b1;
                idx = cand[2:0];
            end
        end
    end

    // Expand the winning index to a one-hot grant.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any && (idx == 3'(i));
        end
    end

endmodule

// File: rtl/sio_host_arbiter.sv
// Host side of an SIO link: NREQ requesters share one staging slot that the
// link drains once per frame. A tag pipe remembers who issued on each frame
// so the read word coming back RLAT frames later is routed to its owner.
module sio_host_arbiter
    import sio_host_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int RLAT = 2
) (
    input  logic                      c,
    input  logic                      r,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [SIO_CMD_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      frame,
    input  logic                      link_ok,
    output logic [SIO_CMD_W-1:0]      tx_data,
    output logic                      tx_valid,
    input  logic                      rx_strobe,
    input  logic [SIO_RD_W-1:0]       rx_data,
    output logic [NREQ-1:0]           resp_valid,
    output logic [SIO_RD_W-1:0]       resp_data,
    output logic                      resp_err,
    output logic [31:0]               status
);

    logic                 slot_full_q, slot_full_d;
    logic [SIO_CMD_W-1:0] tx_data_q,   tx_data_d;
    logic [ID_W-1:0]      slot_id_q,   slot_id_d;
    logic [2:0]           ptr_q,       ptr_d;
    logic [NREQ-1:0]      req_ready_q, req_ready_d;
    tag_t                 tag_q [RLAT];
    tag_t                 tag_d [RLAT];
    logic [NREQ-1:0]      resp_valid_q, resp_valid_d;
    logic [SIO_RD_W-1:0]  resp_data_q,  resp_data_d;
    logic                 resp_err_q,   resp_err_d;
    logic [CNT_W-1:0]     issue_cnt_q,  issue_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q,    err_cnt_d;

    logic [NREQ-1:0]      elig;
    logic [NREQ-1:0]      grant;
    logic [2:0]           win_idx;
    logic                 win_any;
    logic                 consume;
    logic                 load;
    logic [SIO_CMD_W-1:0] sel_word;

    // A requester being acknowledged this cycle still shows its old command;
    // masking it prevents the same word being accepted twice.
    assign elig    = req_valid & ~req_ready_q;
    assign consume = frame && link_ok && slot_full_q;
    assign load    = win_any && (!slot_full_q || (frame && link_ok));

    sio_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (elig),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Select the granted requester's command word.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_word = req_data[SIO_CMD_W*i +: SIO_CMD_W];
            end
        end
    end

    // Next-state for slot, tag pipe, response register and counters.
    always_comb begin
        slot_full_d  = slot_full_q;
        tx_data_d    = tx_data_q;
        slot_id_d    = slot_id_q;
        ptr_d        = ptr_q;
        req_ready_d  = '0;
        tag_d        = tag_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;
        issue_cnt_d  = sat_inc(issue_cnt_q, consume);
        err_cnt_d    = err_cnt_q;

        // Link drained the slot; a same-cycle load below overrides this.
        if (consume) begin
            slot_full_d = 1'b0;
        end

        if (load) begin
            slot_full_d = 1'b1;
            tx_data_d   = sel_word;
            slot_id_d   = win_idx;
            ptr_d       = win_idx;
            req_ready_d = grant;
        end

        // Every frame shifts the pipe; frames that carried no command push v=0.
        if (frame) begin
            tag_d[0] = {consume, slot_id_q, !link_ok};
            for (int k = 1; k < RLAT; k++) begin
                tag_d[k] = tag_q[k-1];
            end
        end

        // The returning word belongs to the oldest tag as it stood before any
        // shift this cycle, so frame and rx_strobe may coincide.
        if (rx_strobe && tag_q[RLAT-1].v) begin
            for (int i = 0; i < NREQ; i++) begin
                resp_valid_d[i] = (tag_q[RLAT-1].id == 3'(i));
            end
            resp_data_d = rx_data;
            resp_err_d  = tag_q[RLAT-1].e || !link_ok;
            err_cnt_d   = sat_inc(err_cnt_q, resp_err_d);
        end
    end

    // State register with synchronous reset; reset drops slot and in-flight tags.
    always_ff @(posedge c) begin
        if (r) begin
            slot_full_q  <= 1'b0;
            tx_data_q    <= '0;
            slot_id_q    <= '0;
            ptr_q        <= 3'(NREQ - 1);
            req_ready_q  <= '0;
            tag_q        <= '{default: '0};
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            issue_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the pre-edge value of the others.
            slot_full_q  <= slot_full_d;
            tx_data_q    <= tx_data_d;
            slot_id_q    <= slot_id_d;
            ptr_q        <= ptr_d;
            req_ready_q  <= req_ready_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            issue_cnt_q  <= issue_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = slot_full_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign status     = {err_cnt_q, issue_cnt_q};

endmodule

// File: tb/tb_sio_host_arbiter.sv
// Self-checking bench for sio_host_arbiter: randomized requesters and link
// timing, checked every cycle against a queue-based reference model.
module tb_sio_host_arbiter;
    import sio_host_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int RLAT = 2;
    localparam int VW   = 4 + 1 + 80 + 4 + 32 + 1 + 32;

    logic                      c = 1'b0;
    logic                      r = 1'b1;
    logic [NREQ-1:0]           req_valid = '0;
    logic [SIO_CMD_W*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]           req_ready;
    logic                      frame = 1'b0;
    logic                      link_ok = 1'b1;
    logic [SIO_CMD_W-1:0]      tx_data;
    logic                      tx_valid;
    logic                      rx_strobe = 1'b0;
    logic [SIO_RD_W-1:0]       rx_data = '0;
    logic [NREQ-1:0]           resp_valid;
    logic [SIO_RD_W-1:0]       resp_data;
    logic                      resp_err;
    logic [31:0]               status;

    always #5 c = ~c;

    sio_host_arbiter #(
        .NREQ (NREQ),
        .RLAT (RLAT)
    ) dut (
        .c          (c),
        .r          (r),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .frame      (frame),
        .link_ok    (link_ok),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .rx_strobe  (rx_strobe),
        .rx_data    (rx_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .status     (status)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus knobs
    int fper      = 6;
    int rx_off    = 0;
    int cyc       = 0;
    int p_new     = 50;
    bit hold_high = 1'b0;

    // reference model: a slot, a last-winner index, a FIFO of frame tags
    typedef struct {
        bit v;
        int id;
        bit e;
    } mtag_t;

    bit              m_full;
    logic [79:0]     m_data;
    int              m_id;
    int              m_ptr;
    logic [NREQ-1:0] m_req_ready;
    logic [NREQ-1:0] m_resp_valid;
    logic [31:0]     m_resp_data;
    bit              m_resp_err;
    int              m_issue;
    int              m_err;
    mtag_t           m_tags[$];

    function automatic logic [79:0] rnd80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {req_ready, tx_valid, tx_data, resp_valid, resp_data, resp_err, status};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_req_ready, m_full, m_data, m_resp_valid, m_resp_data, m_resp_err,
                16'(m_err), 16'(m_issue)};
    endfunction

    task automatic model_reset();
        m_full       = 1'b0;
        m_data       = '0;
        m_id         = 0;
        m_ptr        = NREQ - 1;
        m_req_ready  = '0;
        m_resp_valid = '0;
        m_resp_data  = '0;
        m_resp_err   = 1'b0;
        m_issue      = 0;
        m_err        = 0;
        m_tags.delete();
        repeat (RLAT) m_tags.push_back('{v: 1'b0, id: 0, e: 1'b0});
    endtask

    // Apply one clock edge's worth of the arbitration/link rules.
    task automatic model_step();
        logic [NREQ-1:0] elig;
        int    g;
        bit    issued;
        mtag_t old;
        if (r) begin
            model_reset();
            return;
        end
        elig = req_valid & ~m_req_ready;
        g = -1;
        if (!m_full || (frame && link_ok)) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && elig[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        issued = frame && link_ok && m_full;
        old = m_tags[RLAT-1];
        m_resp_valid = '0;
        m_resp_err   = 1'b0;
        if (rx_strobe && old.v) begin
            m_resp_valid[old.id] = 1'b1;
            m_resp_data = rx_data;
            m_resp_err  = old.e || !link_ok;
            if (m_resp_err && m_err < 65535) m_err++;
        end
        if (frame) begin
            m_tags.push_front('{v: issued, id: m_id, e: !link_ok});
            void'(m_tags.pop_back());
        end
        if (issued && m_issue < 65535) m_issue++;
        m_req_ready = '0;
        if (g >= 0) begin
            m_full = 1'b1;
            m_data = req_data[g*80 +: 80];
            m_id   = g;
            m_ptr  = g;
            m_req_ready[g] = 1'b1;
        end else if (issued) begin
            m_full = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge c);
        model_step();
        @(negedge c);
        cyc++;
    endtask

    task automatic drive_link();
        frame     = (cyc % fper) == (fper - 1);
        rx_strobe = (cyc % fper) == ((fper - 1 + rx_off) % fper);
        rx_data   = $urandom;
    endtask

    // Requesters: after an accept, drop or advance; idle ones sometimes start.
    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (m_req_ready[i]) begin
                if (hold_high || $urandom_range(1, 0) == 1) req_data[i*80 +: 80] = rnd80();
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(99, 0) < p_new) begin
                req_valid[i] = 1'b1;
                req_data[i*80 +: 80] = rnd80();
            end
        end
    endtask

    task automatic run_cycle(input bit reqs);
        drive_link();
        if (reqs) drive_reqs();
        tick();
    endtask

    task automatic do_reset();
        r         = 1'b1;
        req_valid = '0;
        frame     = 1'b0;
        rx_strobe = 1'b0;
        link_ok   = 1'b1;
        hold_high = 1'b0;
        repeat (2) tick();
        r   = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_single();
        int   strobes;
        logic [31:0] want_data;
        do_reset();
        fper = 60;
        rx_off = 30;
        strobes = 0;
        req_valid[1] = 1'b1;
        req_data[80 +: 80] = 80'h1234;
        for (int cur = 0; cur < 240; cur++) begin
            if (m_req_ready[1]) req_valid[1] = 1'b0;
            drive_link();
            if (rx_strobe && cur > fper - 1) strobes++;
            want_data = rx_data;
            tick();
            n_cmp++;
            if (req_ready !== ((cur == 0) ? 4'b0010 : 4'b0000)) begin
                n_bad++;
                $display("FAIL single_ready cyc=%0d: got %b", cur, req_ready);
            end
            n_cmp++;
            if (tx_valid !== (cur < fper - 1)) begin
                n_bad++;
                $display("FAIL single_tx_valid cyc=%0d: got %b want %b", cur, tx_valid, cur < fper - 1);
            end
            n_cmp++;
            if (resp_valid !== ((rx_strobe && strobes == 2) ? 4'b0010 : 4'b0000)) begin
                n_bad++;
                $display("FAIL single_resp_valid cyc=%0d: got %b", cur, resp_valid);
            end
            if (rx_strobe && strobes == 2) begin
                n_cmp++;
                if (resp_data !== want_data || resp_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_resp_data: got %h err %b want %h err 0", resp_data, resp_err, want_data);
                end
            end
        end
        n_cmp++;
        if (tx_data !== 80'h1234) begin
            n_bad++;
            $display("FAIL single_tx_data: got %h want 1234", tx_data);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        do_reset();
        fper = 5;
        rx_off = 2;
        hold_high = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[i*80 +: 80] = rnd80();
        for (int cur = 0; cur < 40; cur++) begin
            run_cycle(1'b1);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL rr_model cyc=%0d: got %h want %h", cur, dut_vec(), model_vec());
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (k >= grants.size() || grants[k] != k % NREQ) begin
                n_bad++;
                $display("FAIL rr_order slot %0d: got %0d want %0d", k,
                         (k < grants.size()) ? grants[k] : -1, k % NREQ);
            end
        end
        n_cmp++;
        if (status[15:0] !== 16'd8) begin
            n_bad++;
            $display("FAIL rr_issue_count: got %0d want 8", status[15:0]);
        end
    endtask

    task automatic test_coincident();
        int n_coinc;
        do_reset();
        fper = 4;
        rx_off = 0;
        p_new = 60;
        n_coinc = 0;
        for (int cur = 0; cur < 200; cur++) begin
            run_cycle(1'b1);
            if (frame && rx_strobe && m_resp_valid != '0 && m_req_ready != '0) n_coinc++;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL coinc_model cyc=%0d: got %h want %h", cur, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (n_coinc == 0) begin
            n_bad++;
            $display("FAIL coinc_seen: got 0 coincident consume+load+response events want >0");
        end
    endtask

    task automatic test_link_loss();
        int n_err_resp;
        do_reset();
        fper = 6;
        rx_off = 0;
        hold_high = 1'b1;
        req_valid = '1;
        n_err_resp = 0;
        for (int i = 0; i < NREQ; i++) req_data[i*80 +: 80] = rnd80();
        for (int cur = 0; cur < 54; cur++) begin
            link_ok = !(cur >= 24 && cur <= 41);
            run_cycle(1'b1);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL loss_model cyc=%0d: got %h want %h", cur, dut_vec(), model_vec());
            end
            if (cur >= 24 && cur <= 41) begin
                if (resp_valid != '0 && resp_err) n_err_resp++;
                n_cmp++;
                if (tx_valid !== 1'b1 || status[15:0] !== 16'd4) begin
                    n_bad++;
                    $display("FAIL loss_hold cyc=%0d: got tx_valid %b issues %0d want 1 and 4", cur, tx_valid, status[15:0]);
                end
            end
        end
        n_cmp++;
        if (n_err_resp != 2) begin
            n_bad++;
            $display("FAIL loss_err_responses: got %0d want 2", n_err_resp);
        end
        n_cmp++;
        if (status !== {16'd2, 16'd6}) begin
            n_bad++;
            $display("FAIL loss_status: got %h want 00020006", status);
        end
    endtask

    task automatic test_idle_reset();
        do_reset();
        fper = 5;
        rx_off = 1;
        for (int cur = 0; cur < 30; cur++) begin
            run_cycle(1'b0);
            n_cmp++;
            if (tx_valid !== 1'b0 || resp_valid !== '0) begin
                n_bad++;
                $display("FAIL idle cyc=%0d: got tx_valid %b resp_valid %b want 0", cur, tx_valid, resp_valid);
            end
        end
        p_new = 70;
        for (int cur = 0; cur < 20; cur++) run_cycle(1'b1);
        r = 1'b1;
        req_valid = '0;
        run_cycle(1'b0);
        r = 1'b0;
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h want 0", dut_vec());
        end
        for (int cur = 0; cur < 15; cur++) begin
            run_cycle(1'b0);
            n_cmp++;
            if (resp_valid !== '0 || tx_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_stale cyc=%0d: got resp_valid %b tx_valid %b want 0", cur, resp_valid, tx_valid);
            end
        end
        req_valid = '1;
        frame = 1'b0;
        rx_strobe = 1'b0;
        tick();
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL midreset_first_winner: got %b want 0001", req_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        p_new = 40;
        for (int seg = 0; seg < 15; seg++) begin
            fper = $urandom_range(8, 2);
            rx_off = $urandom_range(fper - 1, 0);
            for (int cur = 0; cur < 100; cur++) begin
                if ($urandom_range(24, 0) == 0) link_ok = !link_ok;
                run_cycle(1'b1);
                n_cmp++;
                if (dut_vec() !== model_vec()) begin
                    n_bad++;
                    $display("FAIL random seg=%0d cyc=%0d: got %h want %h", seg, cur, dut_vec(), model_vec());
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        fper = 1;
        rx_off = 0;
        hold_high = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[i*80 +: 80] = rnd80();
        repeat (65540) run_cycle(1'b1);
        n_cmp++;
        if (status !== {16'd0, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL sat_issue_count: got %h want 0000ffff", status);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL sat_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_coincident();
        test_link_loss();
        test_idle_reset();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
